// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one variable-latency memory port (req/ack handshake) between the
// CPU instruction-fetch side (i_*) and data side (d_*).  The data side wins
// ties because its access is older in the pipeline; a streak counter limits
// how many consecutive D grants may pass a waiting fetch.  A watchdog aborts
// any access the memory never acknowledges and raises a sticky bus_error.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   i_readM, i_address    fetch request (level) and address
//   i_rdata, i_ready      fetched word and one-cycle completion pulse
//   d_readM, d_writeM     data read / write request (level)
//   d_address, d_wdata    data address and write data
//   d_rdata, d_ready      read data and one-cycle completion pulse
//   m_readM, m_writeM     memory strobes (held for the whole access)
//   m_address, m_wdata    memory address / write data
//   m_rdata, m_ack        memory read data and one-cycle completion
//   bus_error             sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    input  logic                 m_ack,
    output logic                 bus_error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);
    localparam logic [3:0] STREAK_SAT   = 4'hF;
    localparam logic [7:0] TIMEOUT_VAL  = 8'(TIMEOUT);
    localparam logic [WORD_SIZE-1:0] ERR_DATA = {WORD_SIZE{1'b1}};

    state_t     state_r;
    logic [3:0] streak_r;
    logic [7:0] tcnt_r;

    logic       d_req_s;
    logic       grant_d_s;
    logic       grant_i_s;
    logic [3:0] streak_next_s;
    logic [7:0] tcnt_next_s;

    // Arbitration decision for the IDLE edge; D wins unless a waiting fetch
    // has already been passed MAX_D_STREAK times in a row.
    always_comb begin
        d_req_s   = d_readM | d_writeM;
        grant_d_s = d_req_s && (!i_readM || (streak_r < STREAK_LIMIT));
        grant_i_s = !grant_d_s && i_readM;
        if (!i_readM) begin
            streak_next_s = 4'd0;
        end else if (streak_r == STREAK_SAT) begin
            streak_next_s = STREAK_SAT;
        end else begin
            streak_next_s = streak_r + 4'd1;
        end
        tcnt_next_s = tcnt_r + 8'd1;
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            streak_r  <= 4'd0;
            tcnt_r    <= 8'd0;
            i_rdata   <= '0;
            i_ready   <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
            m_readM   <= 1'b0;
            m_writeM  <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            bus_error <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    tcnt_r  <= 8'd0;
                    if (grant_d_s) begin
                        // Read and write together is treated as a write.
                        state_r   <= BUSY_D;
                        m_address <= d_address;
                        m_wdata   <= d_wdata;
                        m_writeM  <= d_writeM;
                        m_readM   <= !d_writeM;
                        streak_r  <= streak_next_s;
                    end else if (grant_i_s) begin
                        state_r   <= BUSY_I;
                        m_address <= i_address;
                        m_wdata   <= '0;
                        m_writeM  <= 1'b0;
                        m_readM   <= 1'b1;
                        streak_r  <= 4'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I, BUSY_D: begin
                    tcnt_r <= tcnt_next_s;
                    if (m_ack || (tcnt_next_s == TIMEOUT_VAL)) begin
                        m_readM  <= 1'b0;
                        m_writeM <= 1'b0;
                        // An ack on the final watchdog cycle still counts as good.
                        if (!m_ack) begin
                            bus_error <= 1'b1;
                        end else begin
                            bus_error <= bus_error;
                        end
                        if (state_r == BUSY_I) begin
                            i_rdata <= m_ack ? m_rdata : ERR_DATA;
                            i_ready <= 1'b1;
                            state_r <= RESP_I;
                        end else begin
                            // Writes leave the last read data visible.
                            if (m_readM) begin
                                d_rdata <= m_ack ? m_rdata : ERR_DATA;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                            d_ready <= 1'b1;
                            state_r <= RESP_D;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                RESP_I, RESP_D: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    i_ready  <= 1'b0;
                    d_ready  <= 1'b0;
                    m_readM  <= 1'b0;
                    m_writeM <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Randomized self-checking bench.  The bench plays both requesters and the
// memory.  A transaction-level model decides which side should win each
// arbitration from the pending requests and a streak count, keeps a memory
// image, and predicts read data, timeouts and the sticky error flag.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int W    = 16;
    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_readM;
    logic [W-1:0] i_address;
    logic [W-1:0] i_rdata;
    logic         i_ready;
    logic         d_readM;
    logic         d_writeM;
    logic [W-1:0] d_address;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_ready;
    logic         m_readM;
    logic         m_writeM;
    logic [W-1:0] m_address;
    logic [W-1:0] m_wdata;
    logic [W-1:0] m_rdata;
    logic         m_ack;
    logic         bus_error;

    always #5 clk = ~clk;

    mem_arbiter #(
        .WORD_SIZE   (W),
        .MAX_D_STREAK(MAXS),
        .TIMEOUT     (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_readM  (i_readM),
        .i_address(i_address),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .d_readM  (d_readM),
        .d_writeM (d_writeM),
        .d_address(d_address),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .m_readM  (m_readM),
        .m_writeM (m_writeM),
        .m_address(m_address),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .bus_error(bus_error)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [W-1:0] mem [0:255];
    int           streak;
    bit           berr;
    logic [W-1:0] exp_i_rdata;
    logic [W-1:0] exp_d_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic new_i();
        i_readM   = 1'b1;
        i_address = W'($urandom);
    endtask

    task automatic new_d();
        int r;
        r         = $urandom_range(0, 19);
        d_address = W'($urandom);
        d_wdata   = W'($urandom);
        d_readM   = (r < 12) || (r == 19);
        d_writeM  = (r >= 12);
    endtask

    task automatic finish_now();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench stopped: no memory strobe");
    endtask

    // Serve one arbitration: predict winner, act as memory, check response.
    task automatic serve(input bit force_noack);
        bit           d_win;
        bit           is_wr;
        bit           noack;
        bit           got;
        int           lat;
        int           n;
        logic [W-1:0] addr;
        logic [W-1:0] wdat;
        logic [W-1:0] rd;

        d_win = (d_readM || d_writeM) && (!i_readM || streak < MAXS);
        if (d_win) begin
            streak = i_readM ? ((streak < 15) ? streak + 1 : 15) : 0;
            addr   = d_address;
            wdat   = d_wdata;
            is_wr  = d_writeM;
        end else begin
            streak = 0;
            addr   = i_address;
            wdat   = '0;
            is_wr  = 1'b0;
        end

        got = 1'b0;
        for (int t = 0; t < 4 && !got; t++) begin
            @(negedge clk);
            got = m_readM | m_writeM;
        end
        check_val("strobe_seen", 32'(got), 32'd1);
        if (!got) finish_now();

        check_val("m_address", 32'(m_address), 32'(addr));
        check_val("m_writeM", 32'(m_writeM), 32'(is_wr));
        check_val("m_readM", 32'(m_readM), 32'(!is_wr));
        if (is_wr) check_val("m_wdata", 32'(m_wdata), 32'(wdat));
        check_val("busy_i_ready", 32'(i_ready), 32'd0);
        check_val("busy_d_ready", 32'(d_ready), 32'd0);

        noack = force_noack || ($urandom_range(0, 11) == 0);
        if (noack) begin
            n = 1;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (m_readM || m_writeM) n++;
                else break;
            end
            check_val("timeout_cycles", 32'(n), 32'(TO));
            berr = 1'b1;
            rd   = {W{1'b1}};
        end else begin
            lat = $urandom_range(1, 4);
            for (int t = 1; t < lat; t++) begin
                @(negedge clk);
                check_val("hold_addr", 32'(m_address), 32'(addr));
                check_val("hold_strobe", 32'(m_readM | m_writeM), 32'd1);
            end
            m_ack   = 1'b1;
            m_rdata = is_wr ? W'($urandom) : mem[addr[7:0]];
            rd      = mem[addr[7:0]];
            if (is_wr) mem[addr[7:0]] = wdat;
            @(negedge clk);
            m_ack   = 1'b0;
            m_rdata = W'($urandom);
        end
        if (!is_wr) begin
            if (d_win) exp_d_rdata = rd;
            else       exp_i_rdata = rd;
        end

        // Ready cycle
        check_val("i_ready", 32'(i_ready), 32'(!d_win));
        check_val("d_ready", 32'(d_ready), 32'(d_win));
        check_val("strobe_drop", 32'(m_readM | m_writeM), 32'd0);
        check_val("i_rdata", 32'(i_rdata), 32'(exp_i_rdata));
        check_val("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
        check_val("bus_error", 32'(bus_error), 32'(berr));

        // Requester that finished drops or replaces its request now.
        if (d_win) begin
            if ($urandom_range(0, 9) < 7) new_d();
            else begin d_readM = 1'b0; d_writeM = 1'b0; end
        end else begin
            if ($urandom_range(0, 9) < 6) new_i();
            else i_readM = 1'b0;
        end

        @(negedge clk);
        check_val("pulse_i_ready", 32'(i_ready), 32'd0);
        check_val("pulse_d_ready", 32'(d_ready), 32'd0);
    endtask

    task automatic run_traffic(input int count, input int force_idx);
        for (int txn = 0; txn < count; txn++) begin
            if (!(i_readM || d_readM || d_writeM)) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if ($urandom_range(0, 2) == 0) begin
                    m_ack   = 1'b1;
                    m_rdata = W'($urandom);
                    @(negedge clk);
                    m_ack = 1'b0;
                    check_val("idle_ack_i_ready", 32'(i_ready), 32'd0);
                    check_val("idle_ack_d_ready", 32'(d_ready), 32'd0);
                end
                case ($urandom_range(0, 2))
                    0:       new_i();
                    1:       new_d();
                    default: begin new_i(); new_d(); end
                endcase
            end
            serve(txn == force_idx);
        end
    endtask

    initial begin
        reset     = 1'b1;
        i_readM   = 1'b0;
        i_address = '0;
        d_readM   = 1'b0;
        d_writeM  = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        m_ack     = 1'b0;
        m_rdata   = '0;
        for (int k = 0; k < 256; k++) mem[k] = W'($urandom);
        streak      = 0;
        berr        = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;

        repeat (3) @(negedge clk);
        check_val("rst_i_ready", 32'(i_ready), 32'd0);
        check_val("rst_d_ready", 32'(d_ready), 32'd0);
        check_val("rst_strobes", 32'(m_readM | m_writeM), 32'd0);
        check_val("rst_m_address", 32'(m_address), 32'd0);
        check_val("rst_rdata", 32'(i_rdata | d_rdata), 32'd0);
        check_val("rst_bus_error", 32'(bus_error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_traffic(150, 3);

        // Reset in the middle of a data access.
        i_readM   = 1'b0;
        d_readM   = 1'b1;
        d_writeM  = 1'b0;
        d_address = 16'h0123;
        @(negedge clk);
        @(negedge clk);
        check_val("mid_strobe", 32'(m_readM), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_val("mid_rst_strobe", 32'(m_readM | m_writeM), 32'd0);
        check_val("mid_rst_addr", 32'(m_address), 32'd0);
        check_val("mid_rst_rdata", 32'(i_rdata | d_rdata), 32'd0);
        check_val("mid_rst_bus_error", 32'(bus_error), 32'd0);
        d_readM = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        for (int t = 0; t < 3; t++) begin
            check_val("late_ack_ready", 32'(i_ready | d_ready), 32'd0);
            @(negedge clk);
        end
        streak      = 0;
        berr        = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;

        run_traffic(20, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory port between the CPU instruction-fetch side and data side.
- Sits between the cpu block's i_*/d_* memory interfaces and a single variable-latency memory with a req/ack handshake.
- Data side has priority, because its MEM-stage access is older; an anti-starvation streak limit guarantees fetch progress.
- A watchdog ends any access the memory never acknowledges.

Parameters:
- WORD_SIZE, 16: address and data width.
- MAX_D_STREAK, 4: maximum consecutive D grants while an I request waits (1..15).
- TIMEOUT, 255: cycles in BUSY without m_ack before the access is aborted (1..255).

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- i_readM  in  1  instruction read request, level, held until i_ready
- i_address  in  WORD_SIZE  instruction address
- i_rdata  out  WORD_SIZE  fetched word, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse for I side
- d_readM  in  1  data read request, level
- d_writeM  in  1  data write request, level
- d_address  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  write data
- d_rdata  out  WORD_SIZE  read data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for D side
- m_readM  out  1  memory read strobe
- m_writeM  out  1  memory write strobe
- m_address  out  WORD_SIZE  memory address
- m_wdata  out  WORD_SIZE  memory write data
- m_rdata  in  WORD_SIZE  memory read data, valid with m_ack
- m_ack  in  1  memory completion, one cycle
- bus_error  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset (asynchronous, any time, including mid-access):
  - State goes to IDLE.
  - All outputs go to 0, including rdata, the streak counter, the timeout counter and bus_error.
  - An in-flight memory access is abandoned; m_ack is ignored until the next grant.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D. Requests are sampled only in IDLE.
- IDLE, with d_req = d_readM|d_writeM:
  - If d_req and (!i_readM or streak<MAX_D_STREAK), go to BUSY_D.
  - Else if i_readM, go to BUSY_I.
  - Else stay in IDLE.
- Grant (IDLE edge), registered:
  - Latch address, wdata and operation into m_* registers.
  - The strobe is high from the next cycle.
  - d_readM and d_writeM both high is illegal; the arbiter treats it as a write.
- Streak counter:
  - On a D grant with i_readM=1, streak+1, saturating at 15.
  - On a D grant with i_readM=0, or on any I grant, streak=0.
- BUSY_x:
  - Strobes and address are held constant.
  - The timeout counter increments each cycle.
  - On an m_ack edge: capture m_rdata into x_rdata (reads only; writes leave d_rdata unchanged), drop strobes, go to RESP_x.
  - If the counter reaches TIMEOUT without m_ack: set bus_error, set x_rdata=16'hFFFF (reads), drop strobes, go to RESP_x.
- RESP_x:
  - x_ready=1 for exactly one cycle, then IDLE unconditionally.
  - The requester must drop or replace its request by the end of the ready cycle.
- m_ack in IDLE or RESP is ignored.
- Latency: request visible at edge 0; strobe cycles 1..k; ack sampled at edge k; ready in cycle k+1; IDLE at edge k+2.
  - The next grant is possible at edge k+2.
  - Minimum is 3 cycles per access with a 1-cycle memory.
- Only one m_* access is outstanding at any time; i_ready and d_ready are never high together.

Test Plan:
- Single I read: i_readM=1, address 0x0010, memory acks 2 cycles after the strobe with 0xBEEF → m_readM high 2 cycles, i_ready pulses once, i_rdata=0xBEEF, d_ready stays 0.
- Simultaneous requests: i_readM and d_readM both raised in the same cycle → D served first, then I; the m_address sequence is d_address, then i_address.
- Starvation: d_readM held continuously with new addresses, i_readM held, MAX_D_STREAK=4 → exactly 4 D grants, then 1 I grant, then the streak restarts at 0.
- Write: d_writeM=1, address 0x0200, d_wdata=0x1234 → m_writeM=1, m_wdata=0x1234; after ack d_ready pulses and d_rdata is unchanged.
- Timeout: TIMEOUT=8, memory never acks → strobe high 8 cycles, then d_ready pulses, d_rdata=0xFFFF, bus_error=1 and stays 1 for later good accesses.
- Reset mid-access: assert reset in BUSY_D → all outputs 0 immediately; an m_ack arriving afterwards produces no ready pulse; normal operation resumes after release.
